// File: rtl/writeback_unit.sv
// Writeback stage: M->W pipeline register, load alignment/extension, and a
// small FSM that stalls the pipeline until variable-latency load data returns.
module writeback_unit #(
    parameter int unsigned D_WIDTH   = 32,
    parameter int unsigned R_WIDTH   = 5,
    parameter int unsigned CNT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_m_i,
    input  logic                 reg_write_m_i,
    input  logic [1:0]           result_src_m_i,
    input  logic [D_WIDTH-1:0]   alu_result_m_i,
    input  logic [D_WIDTH-1:0]   pc_plus4_m_i,
    input  logic [R_WIDTH-1:0]   rd_m_i,
    input  logic [2:0]           funct3_m_i,
    input  logic                 flush_w_i,
    input  logic                 mem_rvalid_i,
    input  logic [D_WIDTH-1:0]   mem_rdata_i,
    output logic                 reg_write_w_o,
    output logic [R_WIDTH-1:0]   rd_w_o,
    output logic [D_WIDTH-1:0]   result_w_o,
    output logic                 stall_o,
    output logic                 misalign_o,
    output logic [CNT_WIDTH-1:0] instret_o
);

    localparam int unsigned OFF = $clog2(D_WIDTH / 8);

    typedef enum logic [1:0] {StIdle, StWaitMem, StDrain} state_e;

    state_e                 state_q, state_d;
    logic                   valid_q;
    logic                   reg_write_q;
    logic [1:0]             result_src_q;
    logic [D_WIDTH-1:0]     alu_q;
    logic [D_WIDTH-1:0]     pc4_q;
    logic [R_WIDTH-1:0]     rd_q;
    logic [2:0]             funct3_q;
    logic [CNT_WIDTH-1:0]   instret_q;

    logic                   is_load;
    logic                   commit;
    logic                   stall;
    logic                   misaligned;
    logic [OFF-1:0]         off;
    logic [D_WIDTH-1:0]     shifted;
    logic [D_WIDTH-1:0]     load_data;

    assign is_load = valid_q && (result_src_q == 2'b01);
    assign off     = alu_q[OFF-1:0];
    assign shifted = mem_rdata_i >> {off, 3'b000};

    // W register: flush kills the entry, stall holds everything else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            result_src_q <= 2'b00;
            alu_q        <= '0;
            pc4_q        <= '0;
            rd_q         <= '0;
            funct3_q     <= 3'b000;
        end else if (flush_w_i) begin
            valid_q      <= 1'b0;
        end else if (!stall) begin
            valid_q      <= valid_m_i;
            reg_write_q  <= reg_write_m_i;
            result_src_q <= result_src_m_i;
            alu_q        <= alu_result_m_i;
            pc4_q        <= pc_plus4_m_i;
            rd_q         <= rd_m_i;
            funct3_q     <= funct3_m_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (commit) begin
                instret_q <= instret_q + 1'b1;
            end
        end
    end

    // Lane select and extension; unrecognised codes pass raw data through
    always_comb begin
        load_data  = mem_rdata_i;
        misaligned = 1'b0;
        case (funct3_q)
            3'b000: load_data = D_WIDTH'($signed(shifted[7:0]));
            3'b100: load_data = D_WIDTH'(shifted[7:0]);
            3'b001: begin
                load_data  = D_WIDTH'($signed(shifted[15:0]));
                misaligned = off[0];
            end
            3'b101: begin
                load_data  = D_WIDTH'(shifted[15:0]);
                misaligned = off[0];
            end
            3'b010: begin
                load_data  = D_WIDTH'($signed(shifted[31:0]));
                misaligned = |off[1:0];
            end
            3'b110: begin
                if (D_WIDTH == 64) begin
                    load_data  = D_WIDTH'(shifted[31:0]);
                    misaligned = |off[1:0];
                end
            end
            3'b011: begin
                if (D_WIDTH == 64) begin
                    load_data  = mem_rdata_i;
                    misaligned = |off;
                end
            end
            default: load_data = mem_rdata_i;
        endcase
    end

    always_comb begin
        result_w_o = '0;
        case (result_src_q)
            2'b00:   result_w_o = alu_q;
            2'b01:   result_w_o = load_data;
            2'b10:   result_w_o = pc4_q;
            default: result_w_o = '0;
        endcase
    end

    // Flush always beats commit; DRAIN swallows the response of a killed load
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        commit  = 1'b0;
        case (state_q)
            StIdle: begin
                if (is_load) begin
                    if (mem_rvalid_i) begin
                        commit = !flush_w_i;
                    end else begin
                        stall   = 1'b1;
                        state_d = flush_w_i ? StDrain : StWaitMem;
                    end
                end else begin
                    commit = valid_q && !flush_w_i;
                end
            end
            StWaitMem: begin
                stall = !mem_rvalid_i;
                if (mem_rvalid_i) begin
                    commit  = is_load && !flush_w_i;
                    state_d = StIdle;
                end else if (flush_w_i) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                stall = !mem_rvalid_i;
                if (mem_rvalid_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign stall_o       = stall;
    assign rd_w_o        = rd_q;
    assign instret_o     = instret_q;
    assign misalign_o    = commit && is_load && misaligned;
    assign reg_write_w_o = valid_q && reg_write_q && (rd_q != '0) && commit
                           && !(is_load && misaligned);

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit (D_WIDTH=32): hand-computed expectations
// for ALU, load extension, stalls, misalignment, flush/drain and reset.
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_m_i;
    logic        reg_write_m_i;
    logic [1:0]  result_src_m_i;
    logic [31:0] alu_result_m_i;
    logic [31:0] pc_plus4_m_i;
    logic [4:0]  rd_m_i;
    logic [2:0]  funct3_m_i;
    logic        flush_w_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        reg_write_w_o;
    logic [4:0]  rd_w_o;
    logic [31:0] result_w_o;
    logic        stall_o;
    logic        misalign_o;
    logic [63:0] instret_o;

    int n_total = 0;
    int n_bad   = 0;

    writeback_unit #(
        .D_WIDTH  (32),
        .R_WIDTH  (5),
        .CNT_WIDTH(64)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_m_i     (valid_m_i),
        .reg_write_m_i (reg_write_m_i),
        .result_src_m_i(result_src_m_i),
        .alu_result_m_i(alu_result_m_i),
        .pc_plus4_m_i  (pc_plus4_m_i),
        .rd_m_i        (rd_m_i),
        .funct3_m_i    (funct3_m_i),
        .flush_w_i     (flush_w_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .reg_write_w_o (reg_write_w_o),
        .rd_w_o        (rd_w_o),
        .result_w_o    (result_w_o),
        .stall_o       (stall_o),
        .misalign_o    (misalign_o),
        .instret_o     (instret_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m(input logic v, input logic rw, input logic [1:0] src,
                           input logic [31:0] alu, input logic [31:0] pc4,
                           input logic [4:0] rd, input logic [2:0] f3);
        valid_m_i      = v;
        reg_write_m_i  = rw;
        result_src_m_i = src;
        alu_result_m_i = alu;
        pc_plus4_m_i   = pc4;
        rd_m_i         = rd;
        funct3_m_i     = f3;
    endtask

    task automatic bubble();
        drive_m(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 3'b000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        flush_w_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
        bubble();
        step();
        step();
        rst_n = 1'b1;
        #1;
        check("rst_we",      reg_write_w_o, 0);
        check("rst_rd",      rd_w_o,        0);
        check("rst_result",  result_w_o,    0);
        check("rst_stall",   stall_o,       0);
        check("rst_misal",   misalign_o,    0);
        check("rst_instret", instret_o,     0);

        // ALU op
        drive_m(1'b1, 1'b1, 2'b00, 32'h1234, 32'h0, 5'd5, 3'b000);
        step();
        bubble();
        #1;
        check("alu_we",     reg_write_w_o, 1);
        check("alu_rd",     rd_w_o,        5);
        check("alu_result", result_w_o,    32'h0000_1234);
        step();
        check("alu_instret", instret_o, 1);
        check("bubble_we",   reg_write_w_o, 0);

        // LB offset 3, zero-wait
        drive_m(1'b1, 1'b1, 2'b01, 32'h1003, 32'h0, 5'd7, 3'b000);
        step();
        bubble();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h80FF_0000;
        #1;
        check("lb_result", result_w_o,    32'hFFFF_FF80);
        check("lb_stall",  stall_o,       0);
        check("lb_we",     reg_write_w_o, 1);
        step();
        mem_rvalid_i = 1'b0;
        check("lb_instret", instret_o, 2);

        // LBU of the same load
        drive_m(1'b1, 1'b1, 2'b01, 32'h1003, 32'h0, 5'd7, 3'b100);
        step();
        bubble();
        mem_rvalid_i = 1'b1;
        #1;
        check("lbu_result", result_w_o, 32'h0000_0080);
        check("lbu_stall",  stall_o,    0);
        step();
        mem_rvalid_i = 1'b0;
        check("lbu_instret", instret_o, 3);

        // LW, response 3 cycles late
        drive_m(1'b1, 1'b1, 2'b01, 32'h2000, 32'h0, 5'd9, 3'b010);
        step();
        bubble();
        for (int i = 0; i < 3; i++) begin
            #1;
            check("lw_stall", stall_o,       1);
            check("lw_nowe",  reg_write_w_o, 0);
            step();
        end
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEAD_BEEF;
        #1;
        check("lw_stall_rel", stall_o,       0);
        check("lw_we",        reg_write_w_o, 1);
        check("lw_rd",        rd_w_o,        9);
        check("lw_result",    result_w_o,    32'hDEAD_BEEF);
        check("lw_instret0",  instret_o,     3);
        step();
        mem_rvalid_i = 1'b0;
        check("lw_instret", instret_o,     4);
        check("lw_single",  reg_write_w_o, 0);

        // LH misaligned
        drive_m(1'b1, 1'b1, 2'b01, 32'h1001, 32'h0, 5'd3, 3'b001);
        step();
        bubble();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1234_5678;
        #1;
        check("lh_mis_we",    reg_write_w_o, 0);
        check("lh_mis_pulse", misalign_o,    1);
        step();
        mem_rvalid_i = 1'b0;
        check("lh_mis_instret", instret_o,  5);
        check("lh_mis_clear",   misalign_o, 0);

        // Flush during WAIT_MEM, response 2 cycles later
        drive_m(1'b1, 1'b1, 2'b01, 32'h3000, 32'h0, 5'd4, 3'b010);
        step();
        bubble();
        #1;
        check("fl_idle_stall", stall_o, 1);
        step();
        flush_w_i = 1'b1;
        #1;
        check("fl_wait_stall", stall_o,       1);
        check("fl_wait_we",    reg_write_w_o, 0);
        step();
        flush_w_i = 1'b0;
        #1;
        check("fl_drain_stall", stall_o, 1);
        step();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hCAFE_F00D;
        drive_m(1'b1, 1'b1, 2'b00, 32'h55, 32'h0, 5'd6, 3'b000);
        #1;
        check("fl_resp_stall", stall_o,       0);
        check("fl_resp_we",    reg_write_w_o, 0);
        step();
        mem_rvalid_i = 1'b0;
        bubble();
        #1;
        check("fl_instret",   instret_o,     5);
        check("fl_next_we",   reg_write_w_o, 1);
        check("fl_next_rd",   rd_w_o,        6);
        check("fl_next_data", result_w_o,    32'h55);
        step();
        check("fl_next_instret", instret_o, 6);

        // rd=0 never writes but still counts
        drive_m(1'b1, 1'b1, 2'b00, 32'h77, 32'h0, 5'd0, 3'b000);
        step();
        bubble();
        #1;
        check("rd0_we", reg_write_w_o, 0);
        step();
        check("rd0_instret", instret_o, 7);

        // pc+4 and zero selects
        drive_m(1'b1, 1'b1, 2'b10, 32'h99, 32'h0000_0104, 5'd1, 3'b000);
        step();
        drive_m(1'b1, 1'b1, 2'b11, 32'h99, 32'h0000_0104, 5'd2, 3'b000);
        #1;
        check("pc4_result", result_w_o,    32'h0000_0104);
        check("pc4_we",     reg_write_w_o, 1);
        step();
        bubble();
        #1;
        check("zero_result", result_w_o, 32'h0);
        step();
        check("sel_instret", instret_o, 9);

        // Reset mid-stall, then a stray response
        drive_m(1'b1, 1'b1, 2'b01, 32'h4000, 32'h0, 5'd10, 3'b010);
        step();
        bubble();
        step();
        #1;
        check("rst_mid_stall", stall_o, 1);
        rst_n = 1'b0;
        #1;
        check("rstm_stall",   stall_o,       0);
        check("rstm_we",      reg_write_w_o, 0);
        check("rstm_rd",      rd_w_o,        0);
        check("rstm_result",  result_w_o,    0);
        check("rstm_instret", instret_o,     0);
        @(negedge clk);
        rst_n        = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hFFFF_FFFF;
        #1;
        check("stray_we",    reg_write_w_o, 0);
        check("stray_stall", stall_o,       0);
        step();
        mem_rvalid_i = 1'b0;
        check("stray_instret", instret_o, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Parametrised writeback stage with its own M->W pipeline register, load-data alignment and sign extension, and a small FSM that stalls the pipeline until a variable-latency data memory returns load data. It sits between the memory stage and the register file write port. It produces the register-file write (enable, rd, data), a pipeline stall request and a retired-instruction counter. It supersedes the purely combinational writeback mux.

## Interface
- D_WIDTH, 32: datapath width; legal values 32 or 64.
- R_WIDTH, 5: register index width.
- CNT_WIDTH, 64: width of the retired-instruction counter.
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- valid_m_i  in  1  M stage holds a valid instruction.
- reg_write_m_i  in  1  instruction writes rd.
- result_src_m_i  in  2  result select: 00 ALU, 01 load, 10 pc+4, 11 zero.
- alu_result_m_i  in  D_WIDTH  ALU result; its low bits are the load byte offset.
- pc_plus4_m_i  in  D_WIDTH  link value.
- rd_m_i  in  R_WIDTH  destination register.
- funct3_m_i  in  3  load size/sign code.
- flush_w_i  in  1  kill the instruction entering or held in W.
- mem_rvalid_i  in  1  load data valid this cycle.
- mem_rdata_i  in  D_WIDTH  raw load data, naturally aligned word/dword.
- reg_write_w_o  out  1  register-file write enable.
- rd_w_o  out  R_WIDTH  write index.
- result_w_o  out  D_WIDTH  write data.
- stall_o  out  1  hold F/D/E/M stages; W register holds.
- misalign_o  out  1  one-cycle pulse: committed load was misaligned and was suppressed.
- instret_o  out  CNT_WIDTH  count of committed (non-flushed) instructions.

## Operation
- W register holds: valid, reg_write, result_src, alu_result, pc_plus4, rd and funct3.
- Update rules for the W register at each rising edge:
  - flush_w_i: valid cleared.
  - else !stall_o: load from M inputs.
  - else: hold.
- Result mux:
  - 00: alu_result.
  - 01: extended load data.
  - 10: pc_plus4.
  - 11: all zero.
- Load extension: the byte offset is alu_result[OFF-1:0], with OFF = log2(D_WIDTH/8). The selected lane is right-justified.
  - funct3 000 LB: sign-extend.
  - 100 LBU: zero-extend.
  - 001 LH: sign-extend.
  - 101 LHU: zero-extend.
  - 010 LW: sign-extend when D_WIDTH=64.
  - 110 LWU: zero-extend (64 only).
  - 011 LD: full word (64 only).
  - Other codes are treated as full-width pass-through.
- Misaligned load: the offset is not a multiple of the access size. The load commits with reg_write_w_o=0 and pulses misalign_o; the counter still increments.
- reg_write_w_o = valid & reg_write & (rd != 0) & commit & !misaligned.
- Commit rule:
  - Non-load: commit when valid.
  - Load: commit only in the cycle mem_rvalid_i=1 while the FSM is in IDLE or WAIT_MEM.
- FSM states:
  - IDLE: valid load in W and !mem_rvalid_i: stall_o=1, next WAIT_MEM. Load with mem_rvalid_i: commit, stay IDLE.
  - WAIT_MEM: stall_o = !mem_rvalid_i. On mem_rvalid_i: commit, next IDLE.
  - DRAIN: entered on flush_w_i in WAIT_MEM, or in IDLE with an unanswered load. stall_o=1, nothing commits. On mem_rvalid_i the response is discarded, stall_o=0 that cycle, next IDLE.
- flush_w_i has priority over commit. A flushed instruction never writes and never counts.
- mem_rvalid_i outside IDLE-with-load, WAIT_MEM or DRAIN is ignored.
- instret_o increments by 1 per commit and wraps modulo 2^CNT_WIDTH.

## Timing
- Reset state: all W register fields 0, FSM IDLE, instret_o 0, every output 0.
- Latency: M inputs are visible on the W outputs one cycle after capture.
- Output paths: result_w_o, reg_write_w_o, stall_o and misalign_o are combinational from the W register, FSM state and mem_* inputs. The register file samples them on the next edge.
- A zero-wait load (mem_rvalid_i in the first W cycle) costs no stall.
- An N-cycle-late load stalls exactly N cycles.
- Reset asserted mid-wait returns the FSM to IDLE immediately. A later stray mem_rvalid_i is ignored.

## Test plan
- ALU op: rd=5, alu=0x1234, src=00. Next cycle: reg_write_w_o=1, rd_w_o=5, result_w_o=0x00001234, instret_o=1.
- LB, offset 3, rdata=0x80FF_0000, rvalid same cycle -> result 0xFFFFFF80, no stall. LBU of the same load -> 0x00000080.
- LW with rvalid 3 cycles late -> stall_o high 3 cycles, single write on the 4th cycle, instret_o+1.
- LH at offset 1 -> reg_write_w_o=0, misalign_o pulse, instret_o+1.
- flush_w_i during WAIT_MEM, response arrives 2 cycles later -> FSM enters DRAIN, no write, stall released in the response cycle, instret_o unchanged.
- rd=0 with reg_write_m_i=1 -> reg_write_w_o=0. Assert rst_n low mid-stall -> all outputs 0, FSM IDLE.
